// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: pipeline <-> hazard controller signal bundle
//  master: pipeline side (drives decode/stage info, receives controls)
//  slave : hazard_ctrl_unit side
//  params: AW register-address width, CNT_W stall counter width
interface hazard_ctrl_unit_if #(parameter int AW = 5, parameter int CNT_W = 16);
  logic          id_valid, id_use_rs, id_use_rt, id_is_md, id_rd_hilo, id_jump;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic          ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, branch_taken;
  logic [1:0]    forward_a, forward_b;
  logic          stall_pc, stall_if_id, bubble_id_ex;
  logic          flush_if_id, flush_id_ex, flush_ex_mem;
  logic          md_busy, md_done;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_valid, id_use_rs, id_use_rt, id_is_md, id_rd_hilo, id_jump,
           id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
           ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, branch_taken,
    input  forward_a, forward_b, stall_pc, stall_if_id, bubble_id_ex,
           flush_if_id, flush_id_ex, flush_ex_mem, md_busy, md_done, stall_cnt
  );
  modport slave (
    input  id_valid, id_use_rs, id_use_rt, id_is_md, id_rd_hilo, id_jump,
           id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
           ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, branch_taken,
    output forward_a, forward_b, stall_pc, stall_if_id, bubble_id_ex,
           flush_if_id, flush_id_ex, flush_ex_mem, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: 5-stage MIPS forwarding, load-use/MULT-DIV stalling and branch/jump flushing
//  ports: clk, reset (sync, active-low), hc (hazard_ctrl_unit_if.slave)
//  params: AW register-address width, MD_LAT MULT/DIV latency (>=2), CNT_W stall counter width
//  PERF_CNT_EN: when defined, hc.stall_cnt is a saturating stall-cycle counter; otherwise tied to 0
module hazard_ctrl_unit #(
  parameter int AW     = 5,
  parameter int MD_LAT = 8,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           reset,
  hazard_ctrl_unit_if.slave hc
);
  localparam int MW = $clog2(MD_LAT);
  localparam logic [MW-1:0] LOAD = MW'(MD_LAT - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [MW-1:0] cnt_q, cnt_d;
  logic md_busy_q, md_busy_d, md_done_q, md_done_d;
  logic lu_stall, md_stall, stall, issue, stall_out;
  always_comb begin
    lu_stall = hc.id_valid && hc.ex_memread && hc.ex_regwrite && hc.ex_rd != '0 &&
               ((hc.id_use_rs && hc.ex_rd == hc.id_rs) || (hc.id_use_rt && hc.ex_rd == hc.id_rt));
    md_stall = md_busy_q && hc.id_valid && (hc.id_is_md || hc.id_rd_hilo);
    stall = lu_stall || md_stall;
    issue = hc.id_valid && hc.id_is_md && !stall && !hc.branch_taken;
    // the counter sits at LOAD outside BUSY so entering BUSY needs no separate load
    cnt_d = (state_q == BUSY) ? cnt_q - MW'(1) : LOAD;
    // a branch in the first BUSY cycle squashes the younger MD op
    state_d = (state_q != BUSY) ? (issue ? BUSY : IDLE) :
              (hc.branch_taken && cnt_q == LOAD) ? IDLE :
              (cnt_q == MW'(1)) ? DONE : BUSY;
    md_busy_d = state_d == BUSY;
    md_done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= LOAD;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
      md_done_q <= md_done_d;
    end
  end
  // flush wins over every stall; reset low silences all outputs
  assign stall_out       = reset && stall && !hc.branch_taken;
  assign hc.stall_pc     = stall_out;
  assign hc.stall_if_id  = stall_out;
  assign hc.bubble_id_ex = stall_out;
  assign hc.flush_if_id  = reset && (hc.branch_taken || (hc.id_jump && !stall));
  assign hc.flush_id_ex  = reset && hc.branch_taken;
  assign hc.flush_ex_mem = reset && hc.branch_taken;
  assign hc.md_busy      = reset && md_busy_q;
  assign hc.md_done      = reset && md_done_q;
  assign hc.forward_a = !reset ? 2'b00 :
                        (hc.mem_regwrite && hc.mem_rd != '0 && hc.mem_rd == hc.ex_rs) ? 2'b10 :
                        (hc.wb_regwrite && hc.wb_rd != '0 && hc.wb_rd == hc.ex_rs) ? 2'b01 : 2'b00;
  assign hc.forward_b = !reset ? 2'b00 :
                        (hc.mem_regwrite && hc.mem_rd != '0 && hc.mem_rd == hc.ex_rt) ? 2'b10 :
                        (hc.wb_regwrite && hc.wb_rd != '0 && hc.wb_rd == hc.ex_rt) ? 2'b01 : 2'b00;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  always_comb stall_cnt_d = (stall_out && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign hc.stall_cnt = reset ? stall_cnt_q : '0;
`else
  assign hc.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed vector and sequence checks for hazard_ctrl_unit
module tb_hazard_ctrl_unit;
  localparam int AW = 5, MD_LAT = 8, CNT_W = 4;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic v, urs, urt, mr, rw, mrw, wrw, br, jmp, st;
    logic [AW-1:0] rs, rt, exrs, exrt, exrd, mrd, wrd;
    logic [1:0] fa, fb;
    logic [2:0] fl;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0, n_bad = 0;
  vec_t tv[18];
  hazard_ctrl_unit_if #(.AW(AW), .CNT_W(CNT_W)) hc();
  hazard_ctrl_unit #(.AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .hc(hc));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chk_ctl(input string nm, input logic st, input logic [2:0] fl);
    chk({nm, ".stall_pc"}, hc.stall_pc, st);
    chk({nm, ".stall_if_id"}, hc.stall_if_id, st);
    chk({nm, ".bubble"}, hc.bubble_id_ex, st);
    chk({nm, ".flush"}, {hc.flush_if_id, hc.flush_id_ex, hc.flush_ex_mem}, fl);
  endtask
  task automatic idle();
    {hc.id_valid, hc.id_use_rs, hc.id_use_rt, hc.id_is_md, hc.id_rd_hilo, hc.id_jump} = '0;
    {hc.id_rs, hc.id_rt, hc.ex_rs, hc.ex_rt, hc.ex_rd, hc.mem_rd, hc.wb_rd} = '0;
    {hc.ex_regwrite, hc.ex_memread, hc.mem_regwrite, hc.wb_regwrite, hc.branch_taken} = '0;
  endtask
  task automatic issue_md();
    idle();
    hc.id_valid = 1'b1;
    hc.id_is_md = 1'b1;
  endtask
  task automatic load_use();
    idle();
    hc.id_valid = 1'b1; hc.id_rs = 5'd2; hc.id_use_rs = 1'b1;
    hc.ex_rd = 5'd2; hc.ex_memread = 1'b1; hc.ex_regwrite = 1'b1;
  endtask
  function automatic vec_t mk(
    input logic v, input logic [AW-1:0] rs, input logic urs, input logic [AW-1:0] rt, input logic urt,
    input logic [AW-1:0] exrs, exrt, exrd, input logic mr, rw,
    input logic [AW-1:0] mrd, input logic mrw, input logic [AW-1:0] wrd, input logic wrw,
    input logic br, jmp, input logic [1:0] fa, fb, input logic st, input logic [2:0] fl);
    vec_t t;
    t.v = v; t.rs = rs; t.urs = urs; t.rt = rt; t.urt = urt;
    t.exrs = exrs; t.exrt = exrt; t.exrd = exrd; t.mr = mr; t.rw = rw;
    t.mrd = mrd; t.mrw = mrw; t.wrd = wrd; t.wrw = wrw; t.br = br; t.jmp = jmp;
    t.fa = fa; t.fb = fb; t.st = st; t.fl = fl;
    return t;
  endfunction
  initial begin
    // v rs urs rt urt | exrs exrt exrd mr rw | mrd mrw wrd wrw | br jmp | fa fb st fl
    tv[0]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0, 2'b00,2'b00,0,3'b000);
    tv[1]  = mk(0,0,0,0,0, 3,0,0,0,0, 3,1,3,1, 0,0, 2'b10,2'b00,0,3'b000);
    tv[2]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,1,0,0, 0,0, 2'b00,2'b00,0,3'b000);
    tv[3]  = mk(0,0,0,0,0, 4,4,0,0,0, 0,0,4,1, 0,0, 2'b01,2'b01,0,3'b000);
    tv[4]  = mk(0,0,0,0,0, 0,5,0,0,0, 5,0,5,1, 0,0, 2'b00,2'b01,0,3'b000);
    tv[5]  = mk(0,0,0,0,0, 7,6,0,0,0, 6,1,7,1, 0,0, 2'b01,2'b10,0,3'b000);
    tv[6]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,1, 0,0, 2'b00,2'b00,0,3'b000);
    tv[7]  = mk(1,2,1,0,0, 0,0,2,1,1, 0,0,0,0, 0,0, 2'b00,2'b00,1,3'b000);
    tv[8]  = mk(1,2,0,0,0, 0,0,2,1,1, 0,0,0,0, 0,0, 2'b00,2'b00,0,3'b000);
    tv[9]  = mk(1,0,0,2,1, 0,0,2,1,0, 0,0,0,0, 0,0, 2'b00,2'b00,0,3'b000);
    tv[10] = mk(1,0,1,0,0, 0,0,0,1,1, 0,0,0,0, 0,0, 2'b00,2'b00,0,3'b000);
    tv[11] = mk(0,2,1,0,0, 0,0,2,1,1, 0,0,0,0, 0,0, 2'b00,2'b00,0,3'b000);
    tv[12] = mk(1,2,1,0,0, 0,0,2,0,1, 0,0,0,0, 0,0, 2'b00,2'b00,0,3'b000);
    tv[13] = mk(1,2,1,0,0, 0,0,2,1,1, 0,0,0,0, 1,0, 2'b00,2'b00,0,3'b111);
    tv[14] = mk(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,1, 2'b00,2'b00,0,3'b100);
    tv[15] = mk(1,2,1,0,0, 0,0,2,1,1, 0,0,0,0, 0,1, 2'b00,2'b00,1,3'b000);
    tv[16] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 1,0, 2'b00,2'b00,0,3'b111);
    tv[17] = mk(1,0,0,9,1, 0,0,9,1,1, 0,0,0,0, 0,0, 2'b00,2'b00,1,3'b000);
    reset = 1'b0;
    idle();
    hc.mem_rd = 5'd3; hc.mem_regwrite = 1'b1; hc.ex_rs = 5'd3; hc.branch_taken = 1'b1;
    hc.id_jump = 1'b1;
    @(negedge clk); #1;
    chk("rst.fa", hc.forward_a, 2'b00);
    chk_ctl("rst", 1'b0, 3'b000);
    chk("rst.busy", hc.md_busy, 1'b0);
    chk("rst.done", hc.md_done, 1'b0);
    chk("rst.cnt", hc.stall_cnt, 0);
    @(negedge clk); reset = 1'b1; idle();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      idle();
      hc.id_valid = tv[i].v; hc.id_rs = tv[i].rs; hc.id_use_rs = tv[i].urs;
      hc.id_rt = tv[i].rt; hc.id_use_rt = tv[i].urt;
      hc.ex_rs = tv[i].exrs; hc.ex_rt = tv[i].exrt; hc.ex_rd = tv[i].exrd;
      hc.ex_memread = tv[i].mr; hc.ex_regwrite = tv[i].rw;
      hc.mem_rd = tv[i].mrd; hc.mem_regwrite = tv[i].mrw;
      hc.wb_rd = tv[i].wrd; hc.wb_regwrite = tv[i].wrw;
      hc.branch_taken = tv[i].br; hc.id_jump = tv[i].jmp;
      #1;
      chk($sformatf("vec%0d.fa", i), hc.forward_a, tv[i].fa);
      chk($sformatf("vec%0d.fb", i), hc.forward_b, tv[i].fb);
      chk_ctl($sformatf("vec%0d", i), tv[i].st, tv[i].fl);
      chk($sformatf("vec%0d.busy", i), hc.md_busy, 1'b0);
    end
    // LW r2 in EX, ADD r2,r5 in ID; then the ADD reaches EX with the load in WB
    @(negedge clk); load_use(); hc.id_rt = 5'd5; hc.id_use_rt = 1'b1; #1;
    chk_ctl("lu.c0", 1'b1, 3'b000);
    @(negedge clk); idle();
    hc.id_valid = 1'b1; hc.id_rs = 5'd2; hc.id_use_rs = 1'b1; hc.id_rt = 5'd5; hc.id_use_rt = 1'b1;
    hc.mem_rd = 5'd2; hc.mem_regwrite = 1'b1; #1;
    chk_ctl("lu.c1", 1'b0, 3'b000);
    @(negedge clk); idle();
    hc.ex_rs = 5'd2; hc.ex_rt = 5'd5; hc.ex_rd = 5'd7; hc.ex_regwrite = 1'b1;
    hc.wb_rd = 5'd2; hc.wb_regwrite = 1'b1; #1;
    chk("lu.c2.fa", hc.forward_a, 2'b01);
    chk("lu.c2.fb", hc.forward_b, 2'b00);
    // MULT then MFLO waiting in ID
    @(negedge clk); issue_md(); #1;
    chk("md.c0.busy", hc.md_busy, 1'b0);
    chk_ctl("md.c0", 1'b0, 3'b000);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); idle(); hc.id_valid = 1'b1; hc.id_rd_hilo = 1'b1; #1;
      chk($sformatf("md.c%0d.busy", c), hc.md_busy, c < 8);
      chk($sformatf("md.c%0d.done", c), hc.md_done, c == 8);
      chk_ctl($sformatf("md.c%0d", c), c < 8, 3'b000);
    end
    @(negedge clk); idle(); #1;
    chk("md.c9.done", hc.md_done, 1'b0);
    // late branch ignored; reissue in the DONE cycle
    @(negedge clk); issue_md(); #1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk); idle();
      if (c == 2) hc.branch_taken = 1'b1;
      if (c == 8) issue_md();
      #1;
      chk($sformatf("re.c%0d.busy", c), hc.md_busy, (c < 8) || (c > 8 && c < 16));
      chk($sformatf("re.c%0d.done", c), hc.md_done, c == 8 || c == 16);
    end
    // branch in the first BUSY cycle aborts the op
    @(negedge clk); issue_md(); #1;
    @(negedge clk); idle(); hc.branch_taken = 1'b1; hc.id_valid = 1'b1; hc.id_rd_hilo = 1'b1; #1;
    chk("ab.c1.busy", hc.md_busy, 1'b1);
    chk_ctl("ab.c1", 1'b0, 3'b111);
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk); idle(); #1;
      chk($sformatf("ab.c%0d.busy", c), hc.md_busy, 1'b0);
      chk($sformatf("ab.c%0d.done", c), hc.md_done, 1'b0);
    end
    // branch in the issue cycle blocks the issue
    @(negedge clk); issue_md(); hc.branch_taken = 1'b1; #1;
    chk_ctl("bi.c0", 1'b0, 3'b111);
    @(negedge clk); idle(); #1;
    chk("bi.c1.busy", hc.md_busy, 1'b0);
    // reset mid-BUSY, then reissue
    @(negedge clk); issue_md(); #1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); idle(); #1;
      chk($sformatf("rb.c%0d.busy", c), hc.md_busy, 1'b1);
    end
    @(negedge clk); idle(); reset = 1'b0; hc.wb_rd = 5'd4; hc.wb_regwrite = 1'b1; hc.ex_rs = 5'd4; #1;
    chk("rb.rst.busy", hc.md_busy, 1'b0);
    chk("rb.rst.fa", hc.forward_a, 2'b00);
    @(negedge clk); reset = 1'b1; issue_md(); #1;
    chk("rb.rel.busy", hc.md_busy, 1'b0);
    chk("rb.rel.cnt", hc.stall_cnt, 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); idle(); #1;
      chk($sformatf("rb.r%0d.busy", c), hc.md_busy, c < 8);
      chk($sformatf("rb.r%0d.done", c), hc.md_done, c == 8);
    end
    // continuous stall: counter saturates at all-ones
    @(negedge clk); idle(); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk); load_use(); #1;
      chk($sformatf("cnt.k%0d", k), hc.stall_cnt, PERF ? ((k > 15) ? 15 : k) : 0);
    end
    @(negedge clk); idle(); #1;
    chk("cnt.hold", hc.stall_cnt, PERF ? 15 : 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
